// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer constants: geometry defaults, FSM states and requester IDs.
package frame_buf_pkg;
  localparam int AW_DEF         = 17;
  localparam int DW_DEF         = 16;
  localparam int FRAME_SIZE_DEF = 160 * 120;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/buffer_wr_arbiter_if.sv
// One pixel-writer port: req/addr/data held until gnt on an accepting edge.
interface buffer_wr_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 16
);
  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          gnt;

  modport master (output req, addr, data, input gnt);
  modport slave  (input req, addr, data, output gnt);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_gnt only moves on an accepted write.
module rr_arb2
  import frame_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt[REQ_A] = 1'b1;
        2'b10:   gnt[REQ_B] = 1'b1;
        // tie goes to whoever did not win last
        2'b11:   if (last_gnt == REQ_B) gnt[REQ_A] = 1'b1;
                 else                   gnt[REQ_B] = 1'b1;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_gnt <= REQ_B;
    else if (accept) last_gnt <= gnt[REQ_B] ? REQ_B : REQ_A;
  end
endmodule

// File: rtl/buffer_wr_arbiter.sv
// Frame-buffer write-port owner: arbitrates writers A/B and runs the frame clear sweep.
module buffer_wr_arbiter
  import frame_buf_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int FRAME_SIZE = FRAME_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_start,
  input  logic [DW-1:0]       clr_color,
  output logic                clr_busy,
  output logic                clr_done,
  buffer_wr_arbiter_if.slave  a_if,
  buffer_wr_arbiter_if.slave  b_if,
  output logic                wr_oob,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_data,
  output logic                mem_we
);
  localparam logic [AW-1:0] LAST = AW'(FRAME_SIZE - 1);

  state_t                 st;
  logic [AW-1:0]          cnt;
  logic [DW-1:0]          color;
  logic [1:0]             req, gnt;
  logic [1:0][AW-1:0]     addr_v;
  logic [1:0][DW-1:0]     data_v;
  logic                   arb_en, acc, sel;

  assign req    = {b_if.req, a_if.req};
  assign addr_v = {b_if.addr, a_if.addr};
  assign data_v = {b_if.data, a_if.data};
  // rst gates grants so nothing looks accepted while the block is held in reset
  assign arb_en = rst && (st == ST_ARB) && !clr_start;
  assign acc    = |gnt;
  assign sel    = gnt[REQ_B] ? REQ_B : REQ_A;

  assign a_if.gnt = gnt[REQ_A];
  assign b_if.gnt = gnt[REQ_B];

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req    (req),
    .accept (acc),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= ST_ARB;
      cnt      <= '0;
      color    <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      wr_oob   <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      wr_oob   <= 1'b0;
      clr_done <= 1'b0;
      case (st)
        ST_ARB: begin
          if (clr_start) begin
            st       <= ST_CLEAR;
            color    <= clr_color;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end else if (acc) begin
            mem_addr <= addr_v[sel];
            mem_data <= data_v[sel];
            if (32'(addr_v[sel]) < 32'(FRAME_SIZE)) mem_we <= 1'b1;
            else                                    wr_oob <= 1'b1;
          end
        end
        ST_CLEAR: begin
          mem_addr <= cnt;
          mem_data <= color;
          mem_we   <= 1'b1;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            st       <= ST_ARB;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: st <= ST_ARB;
      endcase
    end
  end
endmodule
